// File: rtl/timing_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timing_ctrl_pkg
// Shared definitions for the instruction timing controller: the interrupt
// opcode forced into the instruction register, the last legal decoder cycle,
// the FSM state encoding and the service-cause encoding.
// Ports: none (package).
// Optional feature macro used elsewhere: SINGLE_STEP_EN.
// -----------------------------------------------------------------------------
package timing_ctrl_pkg;

  // Opcode injected whenever a reset/NMI/IRQ service sequence is started
  localparam logic [7:0] OP_INT  = 8'h00;

  // Highest decoder cycle number; a further advance request is an overflow
  localparam logic [2:0] CYC_MAX = 3'd7;

  typedef enum logic {
    EXEC  = 1'b0,
    FETCH = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RST  = 2'd1,
    NMI  = 2'd2,
    IRQ  = 2'd3
  } cause_e;

  // Chooses which service sequence to start at the end of a fetch.
  // Reset beats NMI, and NMI beats a maskable IRQ that is not disabled.
  function automatic cause_e pickCause(input logic rstPend,
                                       input logic nmiPend,
                                       input logic irqLevel,
                                       input logic irqMask);
    cause_e c;
    c = NONE;
    if (rstPend)
      c = RST;
    else if (nmiPend)
      c = NMI;
    else if (irqLevel && !irqMask)
      c = IRQ;
    return c;
  endfunction

endpackage

// File: rtl/timing_ctrl_edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Registered rising-edge detector. The previous input value is held in a
// flop; rise_o is high in the cycle where the input is 1 and was 0 the cycle
// before.
// Ports:
//   clk    in  system clock
//   clr    in  synchronous active-high reset (previous value forced to 0)
//   sig_i  in  signal to watch
//   rise_o out one-cycle rising-edge indication
// -----------------------------------------------------------------------------
module edge_det (
  input  logic clk,
  input  logic clr,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last cycle's value so a level that stays high is seen only once
  always_ff @(posedge clk) begin
    if (clr)
      prev_q <= 1'b0;
    else
      prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/timing_ctrl.sv
// -----------------------------------------------------------------------------
// timing_ctrl
// Instruction timing controller. Alternates between FETCH (one clock, opcode
// captured from the data bus) and EXEC (decoder cycles counted under control
// of the decoder's advance/stall/end requests). At the end of each FETCH it
// decides whether to start a reset, NMI or IRQ service sequence instead of
// executing the fetched opcode.
// Optional feature: define SINGLE_STEP_EN to add run/step/halted, which hold
// FETCH while run=0 until a step rising edge releases exactly one instruction.
// Ports:
//   clk       in   system clock
//   clr       in   synchronous active-high reset
//   data_in   in   [7:0] memory data bus (opcode during FETCH)
//   icyc      in   advance decoder cycle
//   scyc      in   stall decoder cycle
//   rcyc      in   end of instruction
//   sinst     in   decoder acknowledges start of a service sequence
//   irq, nmi  in   external interrupt requests
//   i_flag    in   IRQ-disable status bit
//   run       in   (SINGLE_STEP_EN) free-run enable
//   step      in   (SINGLE_STEP_EN) single-step request, rising-edge
//   inst      out  [7:0] instruction register
//   cycle     out  [2:0] decoder cycle number
//   dec_en    out  decoder outputs valid (EXEC)
//   clr_o, nmi_o, irq_o out one-hot service cause
//   err       out  sticky cycle-overflow flag
//   halted    out  (SINGLE_STEP_EN) FETCH held waiting for step
// -----------------------------------------------------------------------------
module timing_ctrl
  import timing_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] data_in,
  input  logic       icyc,
  input  logic       scyc,
  input  logic       rcyc,
  input  logic       sinst,
  input  logic       irq,
  input  logic       nmi,
  input  logic       i_flag,
`ifdef SINGLE_STEP_EN
  input  logic       run,
  input  logic       step,
  output logic       halted,
`endif
  output logic [7:0] inst,
  output logic [2:0] cycle,
  output logic       dec_en,
  output logic       clr_o,
  output logic       nmi_o,
  output logic       irq_o,
  output logic       err
);

  state_e     state_q;
  logic [2:0] cycle_q;
  logic [7:0] inst_q;
  logic       rstPend_q;
  logic       nmiPend_q;
  logic       clrO_q;
  logic       nmiO_q;
  logic       irqO_q;
  logic       err_q;

  logic       nmiRise;
  cause_e     cause_d;
  logic       fetchExit_d;

  // NMI is edge-triggered: a level held high must only request service once
  edge_det uNmiEdge (
    .clk   (clk),
    .clr   (clr),
    .sig_i (nmi),
    .rise_o(nmiRise)
  );

`ifdef SINGLE_STEP_EN
  logic halted_q;
  logic stepArmed_q;
  logic stepRise;

  // A step request is a rising edge, so holding the button does not free-run
  edge_det uStepEdge (
    .clk   (clk),
    .clr   (clr),
    .sig_i (step),
    .rise_o(stepRise)
  );
`endif

  // Service cause candidate and whether the current FETCH may finish this
  // edge. Pending flags are the registered values, so an NMI edge arriving in
  // the exit cycle itself is serviced on the following fetch.
  always_comb begin
    cause_d = pickCause(rstPend_q, nmiPend_q, irq, i_flag);
`ifdef SINGLE_STEP_EN
    fetchExit_d = run | stepArmed_q | stepRise;
`else
    fetchExit_d = 1'b1;
`endif
  end

  // Main controller FSM. EXEC follows the decoder's requests with priority
  // end > stall > advance; FETCH captures either the opcode or the interrupt
  // opcode plus a one-hot cause that stays valid for the whole instruction.
  // The NMI edge update sits after the case so a fresh edge beats an
  // acknowledge arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= FETCH;
      cycle_q   <= 3'd0;
      inst_q    <= OP_INT;
      rstPend_q <= 1'b1;
      nmiPend_q <= 1'b0;
      clrO_q    <= 1'b0;
      nmiO_q    <= 1'b0;
      irqO_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SINGLE_STEP_EN
      halted_q    <= 1'b0;
      stepArmed_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        EXEC: begin
          if (sinst && nmiO_q)
            nmiPend_q <= 1'b0;
          if (sinst && clrO_q)
            rstPend_q <= 1'b0;
          if (rcyc) begin
            state_q <= FETCH;
          end else if (!scyc && icyc) begin
            if (cycle_q == CYC_MAX)
              err_q <= 1'b1;
            else
              cycle_q <= cycle_q + 3'd1;
          end
`ifdef SINGLE_STEP_EN
          halted_q <= rcyc & ~run;
          if (stepRise)
            stepArmed_q <= 1'b1;
`endif
        end
        FETCH: begin
          if (fetchExit_d) begin
            state_q <= EXEC;
            cycle_q <= 3'd0;
            inst_q  <= (cause_d == NONE) ? data_in : OP_INT;
            clrO_q  <= (cause_d == RST);
            nmiO_q  <= (cause_d == NMI);
            irqO_q  <= (cause_d == IRQ);
`ifdef SINGLE_STEP_EN
            halted_q    <= 1'b0;
            stepArmed_q <= 1'b0;
`endif
          end
`ifdef SINGLE_STEP_EN
          else begin
            halted_q <= 1'b1;
          end
`endif
        end
        default: state_q <= FETCH;
      endcase
      if (nmiRise)
        nmiPend_q <= 1'b1;
    end
  end

  assign inst   = inst_q;
  assign cycle  = cycle_q;
  assign dec_en = (state_q == EXEC);
  assign clr_o  = clrO_q;
  assign nmi_o  = nmiO_q;
  assign irq_o  = irqO_q;
  assign err    = err_q;
`ifdef SINGLE_STEP_EN
  assign halted = halted_q;
`endif

endmodule
